// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg -- shared definitions for the instruction fetch block.
//   ADDR_W  : byte-address width of the instruction memory (10)
//   INSTR_W : instruction word width (32)
//   NOP     : canonical no-op encoding (addi x0,x0,0)
//   state_t : fetch FSM state encoding (IDLE, REQ, FULL)
//   pc_add  : modulo-2^ADDR_W address increment helper
package pc_fetch_pkg;

    localparam int ADDR_W  = 10;
    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FULL = 2'd2
    } state_t;

    // Address arithmetic wraps naturally at 2^ADDR_W (3FC + 4 -> 000).
    function automatic logic [ADDR_W-1:0] pc_add(input logic [ADDR_W-1:0] pc,
                                                 input int step);
        return pc + ADDR_W'(step);
    endfunction

endpackage

// File: rtl/pc_fetch_fetch_buf.sv
// fetch_buf -- one-entry holding register for a fetched instruction and its PC.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   load          : capture load_instr/load_pc and mark the entry valid
//   consume       : decode took the entry; mark it empty (data kept)
//   flush         : drop the entry because the fetch stream was redirected
//   load_instr    : instruction word to capture
//   load_pc       : address of that instruction
//   valid         : entry holds an instruction
//   instr, pc     : held instruction word and address
module fetch_buf
    import pc_fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               consume,
    input  logic               flush,
    input  logic [INSTR_W-1:0] load_instr,
    input  logic [ADDR_W-1:0]  load_pc,
    output logic               valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  pc
);

    logic               valid_reg, valid_next;
    logic [INSTR_W-1:0] instr_reg;
    logic [ADDR_W-1:0]  pc_reg;

    // Load wins; the controller never loads and empties in the same cycle.
    always_comb begin
        valid_next = valid_reg;
        if (load) begin
            valid_next = 1'b1;
        end else if (consume || flush) begin
            valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            instr_reg <= '0;
            pc_reg    <= '0;
        end else begin
            valid_reg <= valid_next;
            if (load) begin
                instr_reg <= load_instr;
                pc_reg    <= load_pc;
            end
        end
    end

    assign valid = valid_reg;
    assign instr = instr_reg;
    assign pc    = pc_reg;

endmodule

// File: rtl/pc_fetch.sv
// pc_fetch -- single-outstanding-request instruction fetch unit.
// Fetches one word at a time from instruction memory into a one-entry buffer
// and offers it to decode; taken branches redirect the PC and discard any
// in-flight or buffered instruction.
// Parameters:
//   RESET_PC : first byte address fetched after reset
//   PC_STEP  : sequential PC increment in bytes
// Ports:
//   clk, rst_n                     : clock, asynchronous active-low reset
//   br_valid, br_taken, br_target  : branch-unit redirect
//   imem_req, imem_addr            : instruction-memory read request
//   imem_ack, imem_rdata           : read completion and data
//   if_valid, if_ready             : handshake to decode
//   if_instr, if_pc                : offered instruction and its address
//   redirect_cnt                   : saturating taken-redirect count
//                                    (only when PC_FETCH_PERF_EN is defined)
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 10'h000,
    parameter int                PC_STEP  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               br_valid,
    input  logic               br_taken,
    input  logic [ADDR_W-1:0]  br_target,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc
`ifdef PC_FETCH_PERF_EN
    ,
    output logic [15:0]        redirect_cnt
`endif
);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    // Address of the request on the bus; held while a killed request drains
    // even though pc_reg already points at the branch target.
    logic [ADDR_W-1:0] req_addr_reg, req_addr_next;
    // Set when the outstanding request belongs to a stale stream.
    logic              kill_reg, kill_next;

    logic redirect;
    logic buf_load, buf_consume, buf_flush;

    assign redirect = br_valid & br_taken;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: state_next = REQ;
            // A killed or redirected response leaves us requesting again.
            REQ:  if (imem_ack && !kill_reg && !redirect) state_next = FULL;
            FULL: if (redirect || if_ready) state_next = REQ;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        imem_req    = (state_reg == REQ);
        imem_addr   = req_addr_reg;
        buf_load    = (state_reg == REQ) && imem_ack && !kill_reg && !redirect;
        buf_consume = (state_reg == FULL) && if_ready && !redirect;
        buf_flush   = (state_reg == FULL) && redirect;
    end

    // ----------------------------------------------------------- datapath
    always_comb begin
        pc_next   = pc_reg;
        kill_next = 1'b0;
        if (buf_load) begin
            pc_next = pc_add(pc_reg, PC_STEP);
        end
        // Redirect last so the most recent target always wins.
        if (redirect) begin
            pc_next = br_target;
        end
        // Mid-request: the address must not move until the ack arrives.
        if ((state_reg == REQ) && !imem_ack) begin
            kill_next     = kill_reg | redirect;
            req_addr_next = req_addr_reg;
        end else begin
            req_addr_next = pc_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg       <= RESET_PC;
            req_addr_reg <= RESET_PC;
            kill_reg     <= 1'b0;
        end else begin
            pc_reg       <= pc_next;
            req_addr_reg <= req_addr_next;
            kill_reg     <= kill_next;
        end
    end

    fetch_buf u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (buf_load),
        .consume    (buf_consume),
        .flush      (buf_flush),
        .load_instr (imem_rdata),
        .load_pc    (req_addr_reg),
        .valid      (if_valid),
        .instr      (if_instr),
        .pc         (if_pc)
    );

`ifdef PC_FETCH_PERF_EN
    logic [15:0] redirect_cnt_reg, redirect_cnt_next;

    always_comb begin
        redirect_cnt_next = redirect_cnt_reg;
        if (redirect && (redirect_cnt_reg != 16'hFFFF)) begin
            redirect_cnt_next = redirect_cnt_reg + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_cnt_reg <= '0;
        end else begin
            redirect_cnt_reg <= redirect_cnt_next;
        end
    end

    assign redirect_cnt = redirect_cnt_reg;
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch -- self-checking bench for pc_fetch.
// Build with +define+PC_FETCH_PERF_EN to also cover redirect_cnt.
module tb_pc_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        br_valid = 1'b0, br_taken = 1'b0;
    logic [9:0]  br_target = '0;
    logic        imem_req;
    logic [9:0]  imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_instr;
    logic [9:0]  if_pc;

    // Second instance: RESET_PC near the top of memory, always acked/ready.
    logic        imem_req_w;
    logic [9:0]  imem_addr_w;
    logic        imem_ack_w;
    logic [31:0] imem_rdata_w;
    logic        if_valid_w;
    logic [31:0] if_instr_w;
    logic [9:0]  if_pc_w;
    logic        zero_bit = 1'b0;
    logic [9:0]  zero_addr = '0;
    logic        one_bit = 1'b1;

`ifdef PC_FETCH_PERF_EN
    logic [15:0] redirect_cnt, redirect_cnt_w;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Instruction memory contents: a word that encodes its own address.
    function automatic logic [31:0] mem_word(input logic [9:0] a);
        return {a, ~a, 12'h5A3};
    endfunction

    assign imem_ack_w   = imem_req_w;
    assign imem_rdata_w = mem_word(imem_addr_w);

    pc_fetch dut (
        .clk(clk), .rst_n(rst_n),
        .br_valid(br_valid), .br_taken(br_taken), .br_target(br_target),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_ready(if_ready),
        .if_instr(if_instr), .if_pc(if_pc)
`ifdef PC_FETCH_PERF_EN
        , .redirect_cnt(redirect_cnt)
`endif
    );

    pc_fetch #(.RESET_PC(10'h3FC), .PC_STEP(4)) u_wrap (
        .clk(clk), .rst_n(rst_n),
        .br_valid(zero_bit), .br_taken(zero_bit), .br_target(zero_addr),
        .imem_req(imem_req_w), .imem_addr(imem_addr_w),
        .imem_ack(imem_ack_w), .imem_rdata(imem_rdata_w),
        .if_valid(if_valid_w), .if_ready(one_bit),
        .if_instr(if_instr_w), .if_pc(if_pc_w)
`ifdef PC_FETCH_PERF_EN
        , .redirect_cnt(redirect_cnt_w)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // --------------------------------------------------------- vector table
    typedef struct {
        logic       bv, bt;
        logic [9:0] tgt;
        logic       ack, rdy;
        logic       e_req;
        logic [9:0] e_addr;
        logic       e_val;
        logic [9:0] e_pc;
    } vec_t;

    localparam int NROWS = 28;
    vec_t tbl[NROWS];

    function automatic vec_t mk(input logic bv, input logic bt, input logic [9:0] tgt,
                                input logic ack, input logic rdy,
                                input logic e_req, input logic [9:0] e_addr,
                                input logic e_val, input logic [9:0] e_pc);
        vec_t v;
        v.bv = bv; v.bt = bt; v.tgt = tgt; v.ack = ack; v.rdy = rdy;
        v.e_req = e_req; v.e_addr = e_addr; v.e_val = e_val; v.e_pc = e_pc;
        return v;
    endfunction

    // Outputs are checked against the row, then the row's inputs are driven
    // for the following rising edge.
    task automatic apply_row(input int i);
        chk($sformatf("row%0d_req", i), 32'(imem_req), 32'(tbl[i].e_req));
        if (tbl[i].e_req) chk($sformatf("row%0d_addr", i), 32'(imem_addr), 32'(tbl[i].e_addr));
        chk($sformatf("row%0d_valid", i), 32'(if_valid), 32'(tbl[i].e_val));
        if (tbl[i].e_val) begin
            chk($sformatf("row%0d_pc", i), 32'(if_pc), 32'(tbl[i].e_pc));
            chk($sformatf("row%0d_instr", i), if_instr, mem_word(tbl[i].e_pc));
        end
        if (i == 1) begin
            chk("wrap_req0", 32'(imem_req_w), 32'd1);
            chk("wrap_addr0", 32'(imem_addr_w), 32'h3FC);
        end
        if (i == 2) chk("wrap_pc0", 32'(if_pc_w), 32'h3FC);
        if (i == 3) begin
            chk("wrap_req1", 32'(imem_req_w), 32'd1);
            chk("wrap_addr1", 32'(imem_addr_w), 32'h000);
        end
        $display("row %0d req=%b addr=%h valid=%b pc=%h", i, imem_req, imem_addr, if_valid, if_pc);
        br_valid   = tbl[i].bv;
        br_taken   = tbl[i].bt;
        br_target  = tbl[i].tgt;
        imem_ack   = tbl[i].ack;
        imem_rdata = tbl[i].ack ? mem_word(imem_addr) : 32'h0;
        if_ready   = tbl[i].rdy;
    endtask

    task automatic idle_inputs();
        br_valid = 1'b0; br_taken = 1'b0; br_target = '0;
        imem_ack = 1'b0; imem_rdata = '0; if_ready = 1'b0;
    endtask

    // ------------------------------------------------------ random phase
    // Reference: the stream delivered to decode must be sequential from
    // RESET_PC, restarting at every taken target; a fresh request must use
    // the next expected address and hold it until acked.
    task automatic run_random(input int n);
        logic [9:0]  want_pc = 10'h000;
        logic        after_red = 1'b0, prev_req = 1'b0, prev_ack = 1'b0;
        logic [9:0]  prev_addr = '0;
        logic [15:0] m_cnt = '0;
        int          delivered = 0;
        logic        bv, bt, ack, rdy;
        logic [9:0]  tgt;
        for (int c = 0; c < n; c++) begin
            if (c > 0) @(negedge clk);
            if (after_red) chk("rnd_flush", 32'(if_valid), 32'd0);
            if (if_valid) begin
                chk("rnd_pc", 32'(if_pc), 32'(want_pc));
                chk("rnd_instr", if_instr, mem_word(if_pc));
                chk("rnd_noprefetch", 32'(imem_req), 32'd0);
            end
            if (prev_req && !prev_ack) begin
                chk("rnd_hold_req", 32'(imem_req), 32'd1);
                chk("rnd_hold_addr", 32'(imem_addr), 32'(prev_addr));
            end else if (imem_req) begin
                chk("rnd_new_addr", 32'(imem_addr), 32'(want_pc));
            end
            if (c > 0) chk("rnd_alive", 32'(imem_req | if_valid), 32'd1);
`ifdef PC_FETCH_PERF_EN
            chk("rnd_cnt", 32'(redirect_cnt), 32'(m_cnt));
`endif
            bv  = ($urandom_range(0, 7) == 0);
            bt  = 1'($urandom_range(0, 1));
            tgt = 10'($urandom);
            ack = imem_req && ($urandom_range(0, 2) == 0);
            rdy = 1'($urandom_range(0, 1));
            br_valid = bv; br_taken = bt; br_target = tgt;
            imem_ack = ack;
            imem_rdata = ack ? mem_word(imem_addr) : $urandom;
            if_ready = rdy;
            if (if_valid && rdy) begin
                delivered++;
                want_pc = want_pc + 10'd4;
            end
            if (bv && bt) begin
                want_pc = tgt;
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end
            after_red = bv && bt;
            prev_req  = imem_req;
            prev_ack  = ack;
            prev_addr = imem_addr;
        end
        chk("rnd_delivered_enough", 32'(delivered > 100), 32'd1);
        $display("random phase: %0d instructions delivered", delivered);
    endtask

    initial begin
        tbl[0]  = mk(0,0,10'h000, 1,0, 0,10'h000, 0,10'h000); // ack in IDLE ignored
        tbl[1]  = mk(0,0,10'h000, 1,0, 1,10'h000, 0,10'h000);
        tbl[2]  = mk(0,0,10'h000, 0,1, 0,10'h000, 1,10'h000);
        tbl[3]  = mk(0,0,10'h000, 1,0, 1,10'h004, 0,10'h000);
        tbl[4]  = mk(0,0,10'h000, 0,1, 0,10'h000, 1,10'h004);
        tbl[5]  = mk(0,0,10'h000, 1,0, 1,10'h008, 0,10'h000);
        for (int k = 6; k <= 10; k++)
            tbl[k] = mk(0,0,10'h000, 0,0, 0,10'h000, 1,10'h008); // backpressure
        tbl[11] = mk(0,0,10'h000, 0,1, 0,10'h000, 1,10'h008);
        tbl[12] = mk(0,0,10'h000, 1,0, 1,10'h00C, 0,10'h000);
        tbl[13] = mk(0,0,10'h000, 0,1, 0,10'h000, 1,10'h00C);
        tbl[14] = mk(1,1,10'h100, 0,0, 1,10'h010, 0,10'h000); // redirect while waiting
        tbl[15] = mk(0,0,10'h000, 0,0, 1,10'h010, 0,10'h000);
        tbl[16] = mk(0,0,10'h000, 1,0, 1,10'h010, 0,10'h000); // stale ack
        tbl[17] = mk(0,0,10'h000, 1,0, 1,10'h100, 0,10'h000);
        tbl[18] = mk(0,0,10'h000, 0,1, 0,10'h000, 1,10'h100);
        tbl[19] = mk(1,1,10'h2A0, 1,0, 1,10'h104, 0,10'h000); // redirect + ack
        tbl[20] = mk(1,0,10'h3FF, 0,0, 1,10'h2A0, 0,10'h000); // not taken
        tbl[21] = mk(0,0,10'h000, 1,0, 1,10'h2A0, 0,10'h000);
        tbl[22] = mk(1,1,10'h3FC, 0,0, 0,10'h000, 1,10'h2A0); // redirect in FULL
        tbl[23] = mk(0,0,10'h000, 1,0, 1,10'h3FC, 0,10'h000);
        tbl[24] = mk(1,1,10'h200, 0,1, 0,10'h000, 1,10'h3FC); // redirect + ready
        tbl[25] = mk(0,0,10'h000, 1,0, 1,10'h200, 0,10'h000);
        tbl[26] = mk(0,0,10'h000, 0,1, 0,10'h000, 1,10'h200);
        tbl[27] = mk(0,0,10'h000, 0,0, 1,10'h204, 0,10'h000);

        idle_inputs();
        repeat (3) @(negedge clk);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(if_valid), 32'd0);
        chk("rst_pc", 32'(if_pc), 32'd0);
        chk("rst_instr", if_instr, 32'd0);
`ifdef PC_FETCH_PERF_EN
        chk("rst_cnt", 32'(redirect_cnt), 32'd0);
`endif
        rst_n = 1'b1;
        apply_row(0);
        for (int i = 1; i < NROWS; i++) begin
            @(negedge clk);
            apply_row(i);
        end
        @(negedge clk);
        idle_inputs();
`ifdef PC_FETCH_PERF_EN
        chk("tbl_cnt", 32'(redirect_cnt), 32'd4);
`endif
        // Asynchronous reset while a request to 204 is outstanding.
        #2 rst_n = 1'b0;
        #1;
        chk("midreq_rst_req", 32'(imem_req), 32'd0);
        chk("midreq_rst_valid", 32'(if_valid), 32'd0);
        chk("midreq_rst_pc", 32'(if_pc), 32'd0);
        chk("midreq_rst_instr", if_instr, 32'd0);
`ifdef PC_FETCH_PERF_EN
        chk("midreq_rst_cnt", 32'(redirect_cnt), 32'd0);
`endif
        $display("seq reset mid-request: req=%b valid=%b", imem_req, if_valid);
        @(negedge clk);
        rst_n = 1'b1;
        imem_ack = 1'b1;                 // late ack arriving in IDLE
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("idle_ack_req", 32'(imem_req), 32'd1);
        chk("idle_ack_addr", 32'(imem_addr), 32'h000);
        chk("idle_ack_valid", 32'(if_valid), 32'd0);
        $display("seq idle ack: req=%b addr=%h valid=%b", imem_req, imem_addr, if_valid);
        // Three taken and two not-taken branch pulses.
        for (int k = 0; k < 5; k++) begin
            br_valid = 1'b1;
            br_taken = (k % 2 == 0);
            br_target = 10'($urandom);
            @(negedge clk);
        end
        idle_inputs();
        chk("pulse_req_held", 32'(imem_req), 32'd1);
`ifdef PC_FETCH_PERF_EN
        chk("pulse_cnt", 32'(redirect_cnt), 32'd3);
`endif
        #2 rst_n = 1'b0;
        #1;
`ifdef PC_FETCH_PERF_EN
        chk("pulse_rst_cnt", 32'(redirect_cnt), 32'd0);
`endif
        chk("pulse_rst_req", 32'(imem_req), 32'd0);
        $display("seq redirect pulses done");

        @(negedge clk);
        rst_n = 1'b1;
        run_random(3000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 10'h000, meaning the byte address fetched first after reset.
REQ-002 SHALL have parameter PC_STEP, default 4, meaning the sequential PC increment in bytes.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; asynchronous and active-low.
REQ-005 SHALL have port br_valid, input, 1, a branch-unit result is present this cycle.
REQ-006 SHALL have port br_taken, input, 1, the branch/jump is taken; qualified by br_valid.
REQ-007 SHALL have port br_target, input, 10, the redirect byte address.
REQ-008 SHALL have port imem_req, output, 1, an instruction-memory read request.
REQ-009 SHALL have port imem_addr, output, 10, the request address.
REQ-010 SHALL have port imem_ack, input, 1, the read completes this cycle with data.
REQ-011 SHALL have port imem_rdata, input, 32, the instruction word; valid when imem_ack=1.
REQ-012 SHALL have port if_valid, output, 1, the instruction is offered to decode.
REQ-013 SHALL have port if_ready, input, 1, decode accepts the offered instruction.
REQ-014 SHALL have ports if_instr (output, 32) and if_pc (output, 10): the offered word and its address.
REQ-015 SHALL have port redirect_cnt, output, 16, the taken-redirect count; present only under PC_FETCH_PERF_EN.

Function
REQ-016 SHALL implement FSM states IDLE, REQ, FULL.
- IDLE: one cycle after reset release, then go to REQ.
- REQ: imem_req=1.
- FULL: buffer holds an instruction and if_valid=1.
REQ-017 In REQ, imem_addr SHALL equal pc, and addr SHALL remain stable while imem_req=1 until imem_ack.
REQ-018 On imem_ack in REQ without kill, the block SHALL:
- load imem_rdata and pc into the buffer;
- set pc <= pc+PC_STEP, modulo 2^10 (3FC+4 -> 000);
- go to FULL.
REQ-019 In FULL with if_ready=1, the buffer SHALL be consumed and the next state SHALL be REQ.
REQ-020 In FULL with if_ready=0, if_instr and if_pc SHALL hold.
REQ-021 A redirect (br_valid and br_taken) SHALL set pc <= br_target at the next edge; br_valid with br_taken=0 SHALL have no effect.
REQ-022 A redirect in FULL SHALL drop the buffer: if_valid=0 next cycle and state REQ, with imem_addr=br_target one cycle after the redirect.
REQ-023 A redirect in REQ with imem_ack=0 SHALL set kill; the outstanding request SHALL complete at its original address and be discarded, and the next request SHALL use br_target.
REQ-024 A redirect in REQ in the same cycle as imem_ack SHALL discard that response, leave if_valid at 0, and keep imem_req high at br_target next cycle.
REQ-025 A redirect in the same cycle as if_ready in FULL SHALL be treated as a redirect; the consumed instruction is the already-issued one.
REQ-026 Back-to-back redirects SHALL be handled so the last one wins.
REQ-027 Best-case throughput SHALL be one instruction per two cycles (REQ, FULL); no prefetch is required.

Reset
REQ-028 When rst_n=0, asynchronously:
- pc = RESET_PC and state = IDLE;
- kill = 0;
- imem_req = 0 and if_valid = 0;
- if_instr = 0 and if_pc = 0;
- redirect_cnt = 0.
REQ-029 Reset asserted mid-request SHALL abandon the request; any later imem_ack in IDLE SHALL be ignored.

Configuration
REQ-030 With macro PC_FETCH_PERF_EN defined, redirect_cnt SHALL increment once per accepted redirect and saturate at 16'hFFFF.
REQ-031 Without PC_FETCH_PERF_EN, port redirect_cnt and its counter SHALL be absent; all other behaviour is unchanged.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding and the constants ADDR_W=10, INSTR_W=32 and NOP=32'h00000013.
REQ-033 The block SHALL have one sub-module, fetch_buf: a one-entry instruction/PC holding register with load, consume and flush.

Verification
REQ-034 Reset then idle: release rst_n, ack each request after 1 cycle, if_ready=1 -> imem_addr sequence 000, 004, 008; if_pc matches each.
REQ-035 Backpressure: if_ready=0 for 5 cycles in FULL -> if_instr/if_pc stable, imem_req=0 throughout.
REQ-036 Redirect during wait: request at 010 pending, redirect to 100 -> ack at 010 discarded, next imem_addr=100, next if_pc=100.
REQ-037 Redirect with simultaneous ack, target 2A0 -> no if_valid for that data; next request at 2A0.
REQ-038 Wrap: RESET_PC=3FC -> second request at 000.
REQ-039 With PC_FETCH_PERF_EN, 3 taken and 2 not-taken br_valid pulses -> redirect_cnt=3; reset mid-count -> 0.
